async_fifo_gray_ptr: RTL
========================

ASYNC_FIFO_GRAY_PTR -- requirements
Module: async_fifo_gray_ptr

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, FIFO address width; pointer width PW = ADDR_WIDTH+1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, legal 2..4, remote-pointer synchroniser depth.
REQ-003 SHALL have parameter IS_WRITE, default 1; 1 = write-side pointer (flag means full), 0 = read-side pointer (flag means empty).
REQ-004 SHALL have port clk, input, 1, the only clock; all flops on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port inc, input, 1, request to advance the local pointer.
REQ-007 SHALL have port remote_gptr, input, PW, Gray pointer from the other clock domain, asynchronous to clk.
REQ-008 SHALL have port addr, output, ADDR_WIDTH, RAM address (bin_ptr[ADDR_WIDTH-1:0]).
REQ-009 SHALL have port bin_ptr, output, PW, registered local binary pointer.
REQ-010 SHALL have port gray_ptr, output, PW, registered local Gray pointer, for export to the other domain.
REQ-011 SHALL have port remote_bptr, output, PW, binary decode of the last synchroniser stage.
REQ-012 SHALL have port flag, output, 1, registered full (IS_WRITE=1) or empty (IS_WRITE=0).
REQ-013 SHALL have port err, output, 1, sticky error: inc seen while flag=1.

Function
REQ-014 SHALL accept an increment when inc=1 and flag=0; accepted: bin_ptr <= bin_ptr+1 mod 2^PW, gray_ptr <= gray of bin_ptr+1, same edge.
REQ-015 SHALL leave pointers unchanged when inc=1 and flag=1, and set err=1 at that edge; err stays 1 until rst.
REQ-016 SHALL produce gray_ptr directly from a flop (no output logic), so exactly one bit changes per accepted increment, including wrap 2^PW-1 -> 0.
REQ-017 SHALL synchronise remote_gptr through SYNC_STAGES flops; no other logic in that path.
REQ-018 SHALL compute remote_bptr combinationally from the last stage: b[PW-1]=g[PW-1], b[i]=b[i+1]^g[i].
REQ-019 SHALL register flag every cycle from gnext (next gray pointer, accounting for REQ-014/015) and rsync (last sync stage).
REQ-020 IS_WRITE=1: flag_next = (gnext == {~rsync[PW-1:PW-2], rsync[PW-3:0]}).
REQ-021 IS_WRITE=0: flag_next = (gnext == rsync).
REQ-022 Latency: remote_gptr change reaches rsync after SYNC_STAGES edges; flag reflects it one edge later.
REQ-023 Accepted inc that makes the FIFO full/empty SHALL set flag at the same edge the pointer updates (no extra cycle).

Reset
REQ-024 On rst=1 at an edge: bin_ptr=0, gray_ptr=0, all sync stages=0, err=0, flag=0 (IS_WRITE=1) or 1 (IS_WRITE=0).
REQ-025 rst SHALL dominate inc, including mid-sequence and while flag=1.

Structure
REQ-026 Shared package async_fifo_pkg SHALL hold default ADDR_WIDTH, SYNC_STAGES limits and a Gray<->binary function pair.
REQ-027 Gray-to-binary decode SHALL be the sub-module async_fifo_gcodetobin, parametrised by SIGNAL_WIDTH, combinational.
REQ-028 Illegal SYNC_STAGES or ADDR_WIDTH<1 SHALL be rejected at elaboration.

Verification (ADDR_WIDTH=3, PW=4, SYNC_STAGES=2)
REQ-029 Reset: rst 1 cycle -> bin_ptr=0, gray_ptr=0, err=0; flag=0 write, flag=1 read.
REQ-030 Write fill: IS_WRITE=1, remote_gptr=0, inc held 9 cycles -> after 8th edge bin_ptr=4'b1000, gray_ptr=4'b1100, flag=1; 9th inc ignored, err=1.
REQ-031 Wrap: IS_WRITE=1, remote_gptr tracking gray_ptr delayed, 17 incs -> bin_ptr 15->0, gray_ptr 4'b1000->4'b0000, one-bit change every step, flag never 1.
REQ-032 Read latency: IS_WRITE=0, after reset drive remote_gptr=4'b0011 -> remote_bptr=4'b0010 after edge 2, flag=0 after edge 3; two incs -> flag=1 at edge of 2nd inc.
REQ-033 Reset mid-op: IS_WRITE=0, bin_ptr=5, rst with inc=1 -> bin_ptr=0, flag=1, err=0 next edge.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer logic.
// Holds the default geometry, the legal synchroniser depth range and a
// Gray <-> binary conversion pair usable at any width up to 32 bits
// (narrower values are zero-extended; leading zeros do not affect either
// conversion).
package async_fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 3;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int SYNC_STAGES_MIN     = 2;
  localparam int SYNC_STAGES_MAX     = 4;
  localparam int MAX_PTR_WIDTH       = 32;

  function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(input logic [MAX_PTR_WIDTH-1:0] g);
    logic [MAX_PTR_WIDTH-1:0] b;
    b[MAX_PTR_WIDTH-1] = g[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_fifo_gcodetobin.sv
// Combinational Gray-code to binary decoder.
// Ports:
//   gray_in [SIGNAL_WIDTH-1:0]  Gray-coded value
//   bin_out [SIGNAL_WIDTH-1:0]  binary equivalent
// Each binary bit is the XOR of the Gray bits at and above its position,
// which is the unrolled form of b[i] = b[i+1] ^ g[i].
module async_fifo_gcodetobin #(
  parameter int SIGNAL_WIDTH = 4
) (
  input  logic [SIGNAL_WIDTH-1:0] gray_in,
  output logic [SIGNAL_WIDTH-1:0] bin_out
);

  for (genvar i = 0; i < SIGNAL_WIDTH; i++) begin : g_bit
    assign bin_out[i] = ^(gray_in >> i);
  end

endmodule

// File: rtl/async_fifo_gray_ptr.sv
// One side (write or read) of an asynchronous FIFO pointer pair.
// Keeps the local binary and Gray pointers, synchronises the remote Gray
// pointer into this clock domain and produces a registered full/empty flag.
// Ports:
//   clk          clock, all flops on the rising edge
//   rst          synchronous active-high reset
//   inc          request to advance the local pointer
//   remote_gptr  Gray pointer from the other domain (asynchronous)
//   addr         RAM address (low bits of bin_ptr)
//   bin_ptr      registered local binary pointer
//   gray_ptr     registered local Gray pointer, exported to the other domain
//   remote_bptr  binary decode of the last synchroniser stage
//   flag         registered full (IS_WRITE=1) or empty (IS_WRITE=0)
//   err          sticky: inc requested while flag was set
module async_fifo_gray_ptr
  import async_fifo_pkg::*;
#(
  parameter int  ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int  SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int  IS_WRITE    = 1,
  localparam int PW          = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic [PW-1:0]         remote_gptr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [PW-1:0]         bin_ptr,
  output logic [PW-1:0]         gray_ptr,
  output logic [PW-1:0]         remote_bptr,
  output logic                  flag,
  output logic                  err
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("async_fifo_gray_ptr: SYNC_STAGES must be in 2..4");
  end
  if (ADDR_WIDTH < 1 || PW > MAX_PTR_WIDTH) begin : g_bad_addr
    $error("async_fifo_gray_ptr: ADDR_WIDTH must be in 1..31");
  end

  // Full when the pointers are one lap apart: the two MSBs of the Gray
  // codes differ and the rest match.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] bin_q,  bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic          flag_q, flag_d;
  logic          err_q,  err_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic [PW-1:0] rsync;
  logic          accept;

  assign rsync = sync_q[SYNC_STAGES-1];

  // Plain shift chain: nothing may sit between the stages.
  always_comb begin
    sync_d[0] = remote_gptr;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // The flag is evaluated against the post-increment pointer so that the
  // increment which fills/empties the FIFO raises the flag on the same edge.
  always_comb begin
    accept = inc & ~flag_q;
    bin_d  = bin_q + PW'(accept);
    gray_d = PW'(bin2gray(MAX_PTR_WIDTH'(bin_d)));
    err_d  = err_q | (inc & flag_q);
    if (IS_WRITE != 0) begin
      flag_d = (gray_d == (rsync ^ FULL_MASK));
    end else begin
      flag_d = (gray_d == rsync);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      err_q  <= 1'b0;
      flag_q <= (IS_WRITE == 0);
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      err_q  <= err_d;
      flag_q <= flag_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  async_fifo_gcodetobin #(
    .SIGNAL_WIDTH(PW)
  ) u_gcodetobin (
    .gray_in(rsync),
    .bin_out(remote_bptr)
  );

  assign addr     = bin_q[ADDR_WIDTH-1:0];
  assign bin_ptr  = bin_q;
  assign gray_ptr = gray_q;
  assign flag     = flag_q;
  assign err      = err_q;

endmodule
